sync_fifo_rdctrl_fwft: RTL

Parametrised next-generation read controller for the synchronous FIFO. It owns the read pointer, which carries an extra wrap bit, and computes empty, fill level, almost-empty and underflow. It supports two modes: standard (data one cycle after pop) and first-word-fall-through (FWFT, head word presented before pop). It sits between the read-side consumer and the FIFO memory's registered read port, alongside the write controller, which consumes rptr_o for its full flag.

---
 rtl/sync_fifo_pkg.sv | 17 +
 rtl/sync_fifo_fwft_stage.sv | 57 +++++
 rtl/sync_fifo_rdctrl_fwft.sv | 109 ++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO read and write controllers.
package sync_fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Occupancy between two pointers that carry a wrap bit above aw address bits.
    function automatic logic [31:0] ptr_diff(input logic [31:0] wp, input logic [31:0] rp,
                                             input int unsigned aw);
        logic [31:0] mask;
        mask = (32'd1 << (aw + 1)) - 32'd1;
        return (wp - rp) & mask;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft_stage.sv
// First-word-fall-through output stage: holding register, in-flight tracking and
// the prefetch decision for the memory's registered read port.
module sync_fifo_fwft_stage
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic          rclk_i,
    input  logic          rst_n,
    input  logic          rd_en_i,
    input  logic          mem_nonempty_i,
    input  logic [DW-1:0] rdata_i,
    output logic          fetch_o,
    output logic          avail_o,
    output logic [DW-1:0] rdata_o
);

    logic          out_v_q, out_v_d;
    logic          inflight_q, inflight_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          pop;

    assign avail_o = out_v_q | inflight_q;
    assign pop     = rd_en_i & avail_o;
    assign fetch_o = mem_nonempty_i & (~avail_o | pop);
    // Bypass the holding register while a word is arriving so streaming has no bubble.
    assign rdata_o = inflight_q ? rdata_i : hold_q;

    always_comb begin
        out_v_d    = out_v_q;
        hold_d     = hold_q;
        inflight_d = fetch_o;
        if (inflight_q && !pop) begin
            hold_d  = rdata_i;
            out_v_d = 1'b1;
        end else if (pop && !inflight_q) begin
            out_v_d = 1'b0;
        end
    end

    always_ff @(posedge rclk_i or negedge rst_n) begin
        if (!rst_n) begin
            out_v_q    <= 1'b0;
            inflight_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            out_v_q    <= out_v_d;
            inflight_q <= inflight_d;
            hold_q     <= hold_d;
        end
    end

    // A fetch is only issued when the holder is empty or draining, so both never coexist.
    a_single_word: assert property (@(posedge rclk_i) disable iff (!rst_n)
        !(out_v_q && inflight_q));

endmodule

// File: rtl/sync_fifo_rdctrl_fwft.sv
// Read-side controller for the synchronous FIFO: read pointer with wrap bit, status
// flags and either a one-cycle-latency or a first-word-fall-through consumer port.
module sync_fifo_rdctrl_fwft
    import sync_fifo_pkg::*;
#(
    parameter int unsigned AW        = 7,
    parameter int unsigned DW        = 32,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned AE_THRESH = 4
) (
    input  logic          rclk_i,
    input  logic          rst_n,
    input  logic          rd_en_i,
    input  logic [AW:0]   wpnt_i,
    input  logic [DW-1:0] rdata_i,
    output logic          mem_ren_o,
    output logic [AW-1:0] rpnt_o,
    output logic [AW:0]   rptr_o,
    output logic [DW-1:0] rdata_o,
    output logic          rvalid_o,
    output logic          empty_o,
    output logic          almost_empty_o,
    output logic [AW:0]   level_o,
    output logic          underflow_o
);

    localparam fifo_mode_e  Mode     = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
    localparam int unsigned PW       = AW + 1;
    localparam logic [AW:0] Depth    = PW'(2 ** AW);
    localparam logic [AW:0] AeThresh = PW'(AE_THRESH);

    logic [AW:0] rptr_q, rptr_d;
    logic [AW:0] mem_cnt;
    logic        adv;
    logic        empty;
    logic        underflow_q, underflow_d;

    assign mem_cnt = PW'(ptr_diff(32'(wpnt_i), 32'(rptr_q), AW));

    if (Mode == FIFO_FWFT) begin : g_fwft
        logic fetch;
        logic avail;

        sync_fifo_fwft_stage #(
            .DW(DW)
        ) u_stage (
            .rclk_i         (rclk_i),
            .rst_n          (rst_n),
            .rd_en_i        (rd_en_i),
            .mem_nonempty_i (mem_cnt != '0),
            .rdata_i        (rdata_i),
            .fetch_o        (fetch),
            .avail_o        (avail),
            .rdata_o        (rdata_o)
        );

        assign adv       = fetch;
        assign mem_ren_o = fetch;
        assign rvalid_o  = avail;
        assign empty     = ~avail;
        assign level_o   = mem_cnt + PW'(avail);
    end else begin : g_std
        logic rvalid_q;

        assign empty     = (rptr_q == wpnt_i);
        assign adv       = rd_en_i & ~empty;
        assign mem_ren_o = adv;
        assign rvalid_o  = rvalid_q;
        assign rdata_o   = rdata_i;
        assign level_o   = mem_cnt;

        always_ff @(posedge rclk_i or negedge rst_n) begin
            if (!rst_n) begin
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= adv;
            end
        end
    end

    always_comb begin
        rptr_d      = rptr_q;
        underflow_d = rd_en_i & empty;
        if (adv) begin
            rptr_d = rptr_q + PW'(1);
        end
    end

    always_ff @(posedge rclk_i or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            rptr_q      <= rptr_d;
            underflow_q <= underflow_d;
        end
    end

    assign rpnt_o         = rptr_q[AW-1:0];
    assign rptr_o         = rptr_q;
    assign empty_o        = empty;
    assign almost_empty_o = (level_o <= AeThresh);
    assign underflow_o    = underflow_q;

    // The write controller must never let the memory hold more than its depth.
    a_mem_cnt_legal: assert property (@(posedge rclk_i) disable iff (!rst_n)
        mem_cnt <= Depth);

endmodule
